// File: rtl/abs_pkg.sv
// Shared channel state encoding and default timing constants for the ABS valve driver.
package abs_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'b00,
    CH_PEAK = 2'b01,
    CH_HOLD = 2'b10
  } ch_state_e;

  localparam int PEAK_CYCLES_DEF = 8;
  localparam int PWM_PERIOD_DEF  = 16;
  localparam int HOLD_DUTY_DEF   = 6;
  localparam int MIN_DWELL_DEF   = 4;
  localparam int PUMP_MIN_ON_DEF = 32;

endpackage

// File: rtl/abs_solenoid_ph.sv
// One peak-and-hold solenoid channel: full-on burst at energisation, then PWM hold.
module abs_solenoid_ph
  import abs_pkg::*;
#(
  parameter int PEAK_CYCLES = PEAK_CYCLES_DEF,
  parameter int PWM_PERIOD  = PWM_PERIOD_DEF,
  parameter int HOLD_DUTY   = HOLD_DUTY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_i,
  input  logic force_off_i,
  output logic drive_o
);

  localparam int CNT_MAX = (PEAK_CYCLES > PWM_PERIOD) ? PEAK_CYCLES : PWM_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PEAK_LAST = CW'(PEAK_CYCLES - 1);
  localparam logic [CW-1:0] PWM_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DUTY_V    = CW'(HOLD_DUTY);

  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drive_q, drive_d;

  // Channel state register; drive is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_OFF;
      cnt_q   <= '0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
    end
  end

  // Next-state and drive decode; cnt counts peak cycles, then PWM phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drive_d = 1'b0;
    if (force_off_i) begin
      state_d = CH_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CH_OFF: begin
          cnt_d = '0;
          if (cmd_i) begin
            state_d = CH_PEAK;
            drive_d = 1'b1;
          end else begin
            state_d = CH_OFF;
          end
        end
        CH_PEAK: begin
          if (!cmd_i) begin
            state_d = CH_OFF;
            cnt_d   = '0;
          end else if (cnt_q == PEAK_LAST) begin
            state_d = CH_HOLD;
            cnt_d   = '0;
            drive_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            drive_d = 1'b1;
          end
        end
        CH_HOLD: begin
          if (!cmd_i) begin
            state_d = CH_OFF;
            cnt_d   = '0;
          end else begin
            if (cnt_q == PWM_LAST) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
            drive_d = (cnt_d < DUTY_V);
          end
        end
        default: begin
          state_d = CH_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign drive_o = drive_q;

endmodule

// File: rtl/abs_valve_driver.sv
// ABS valve/pump driver: registers controller commands, enforces dwell and pump
// minimum-on timing, and drives two peak-and-hold solenoid channels.
module abs_valve_driver
  import abs_pkg::*;
#(
  parameter int PEAK_CYCLES = PEAK_CYCLES_DEF,
  parameter int PWM_PERIOD  = PWM_PERIOD_DEF,
  parameter int HOLD_DUTY   = HOLD_DUTY_DEF,
  parameter int MIN_DWELL   = MIN_DWELL_DEF,
  parameter int PUMP_MIN_ON = PUMP_MIN_ON_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Vrc1,
  input  logic       Vrc2,
  input  logic       recovery_pump,
  input  logic       engine_status,
  output logic       inlet_drive,
  output logic       outlet_drive,
  output logic       pump_motor,
  output logic [1:0] valve_state,
  output logic       cmd_fault
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int PW = $clog2(PUMP_MIN_ON + 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL - 1);
  localparam logic [PW-1:0] PUMP_LOAD  = PW'(PUMP_MIN_ON - 1);

  logic [1:0]    cmd_s1_q;
  logic          pump_s1_q, eng_s1_q;
  logic [1:0]    valve_q, valve_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] pump_cnt_q, pump_cnt_d;
  logic          pump_q, pump_d, fault_q, fault_d;
  logic [1:0]    cmd_m;
  logic          accept;

  // Stage-1 input capture and accepted-command/pump state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_s1_q   <= 2'b00;
      pump_s1_q  <= 1'b0;
      eng_s1_q   <= 1'b0;
      valve_q    <= 2'b00;
      dwell_q    <= '0;
      pump_cnt_q <= '0;
      pump_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      cmd_s1_q   <= {Vrc2, Vrc1};
      pump_s1_q  <= recovery_pump;
      eng_s1_q   <= engine_status;
      valve_q    <= valve_d;
      dwell_q    <= dwell_d;
      pump_cnt_q <= pump_cnt_d;
      pump_q     <= pump_d;
      fault_q    <= fault_d;
    end
  end

  // Outlet-open without inlet-close is illegal and is promoted to both valves.
  assign cmd_m  = (cmd_s1_q == 2'b10) ? 2'b11 : cmd_s1_q;
  assign accept = eng_s1_q && (cmd_m != valve_q) && (dwell_q == '0);

  // Command acceptance, dwell timer and pump minimum-on timer; engine-off wins.
  always_comb begin
    valve_d    = valve_q;
    dwell_d    = dwell_q;
    pump_d     = pump_q;
    pump_cnt_d = pump_cnt_q;
    fault_d    = fault_q | (accept && (cmd_s1_q == 2'b10));
    if (!eng_s1_q) begin
      valve_d    = 2'b00;
      dwell_d    = '0;
      pump_d     = 1'b0;
      pump_cnt_d = '0;
    end else begin
      if (accept) begin
        valve_d = cmd_m;
        dwell_d = DWELL_LOAD;
      end else if (dwell_q != '0) begin
        dwell_d = dwell_q - DW'(1);
      end else begin
        dwell_d = dwell_q;
      end
      if (!pump_q) begin
        if (pump_s1_q) begin
          pump_d     = 1'b1;
          pump_cnt_d = PUMP_LOAD;
        end else begin
          pump_d = 1'b0;
        end
      end else if (pump_cnt_q != '0) begin
        pump_d     = 1'b1;
        pump_cnt_d = pump_cnt_q - PW'(1);
      end else begin
        pump_d = pump_s1_q;
      end
    end
  end

  abs_solenoid_ph #(
    .PEAK_CYCLES(PEAK_CYCLES), .PWM_PERIOD(PWM_PERIOD), .HOLD_DUTY(HOLD_DUTY)
  ) u_inlet (
    .clk(clk), .reset(reset), .cmd_i(valve_q[0]), .force_off_i(~eng_s1_q),
    .drive_o(inlet_drive)
  );

  abs_solenoid_ph #(
    .PEAK_CYCLES(PEAK_CYCLES), .PWM_PERIOD(PWM_PERIOD), .HOLD_DUTY(HOLD_DUTY)
  ) u_outlet (
    .clk(clk), .reset(reset), .cmd_i(valve_q[1]), .force_off_i(~eng_s1_q),
    .drive_o(outlet_drive)
  );

  assign pump_motor  = pump_q;
  assign valve_state = valve_q;
  assign cmd_fault   = fault_q;

endmodule
